hht_mem_arbiter: RTL and testbench

HHT_MEM_ARBITER -- requirements
Module: hht_mem_arbiter

---
 rtl/hht_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_hht_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hht_mem_arbiter.sv
// ---------------------------------------------------------------------------
// hht_mem_arbiter
//
// Purpose:
//   This block shares one single-port memory read channel between two burst
//   requesters:
//     - requester 0 fetches columns
//     - requester 1 fetches v-values
//   Each requester hands over a start word address and a length. The block
//   then issues one read beat per cycle on the shared memory port. Read data
//   comes back one cycle later on that requester's rdata/rvalid pair.
//
//   While both requesters have work pending, a grant lasts at most CHUNK
//   beats. The hand-over from one grant to the other costs no cycles.
//
// Ports:
//   clk_i            single clock; all state changes on the rising edge
//   rst_ni           asynchronous, active-low reset
//   reqN_i           burst request; sampled only while busyN_o = 0
//   baseN_i, lenN_i  burst start word address and length in words
//   busyN_o          burst accepted and not yet complete
//   doneN_o          one-cycle completion pulse; busyN_o is already 0 here
//   rvalidN_o        rdataN_o holds a returned read word
//   rdataN_o         returned read word
//   mem_rd_o         shared memory read strobe
//   mem_addr_o       shared memory read address; holds its value while idle
//   mem_data_i       memory data, combinational from mem_addr_o
// ---------------------------------------------------------------------------
module hht_mem_arbiter #(
  parameter int CHUNK = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req0_i,
  input  logic [AW-1:0] base0_i,
  input  logic [AW-1:0] len0_i,
  input  logic          req1_i,
  input  logic [AW-1:0] base1_i,
  input  logic [AW-1:0] len1_i,
  output logic          busy0_o,
  output logic          busy1_o,
  output logic          done0_o,
  output logic          done1_o,
  output logic          rvalid0_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata0_o,
  output logic [DW-1:0] rdata1_o,
  output logic          mem_rd_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_data_i
);

  // Chunk counter width. It counts beats 0 .. CHUNK-1 within one grant.
  localparam int CW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [AW-1:0] last_addr_q;

  // ------------------------------------------------------------------
  // Per-requester views, indexed by requester number.
  // ------------------------------------------------------------------
  logic [1:0]    req_w;
  logic [1:0]    busy_w;
  logic [1:0]    done_w;
  logic [1:0]    rvalid_w;
  logic [1:0]    active_w;
  logic [1:0]    issue_w;
  logic [AW-1:0] base_w  [2];
  logic [AW-1:0] len_w   [2];
  logic [AW-1:0] addr_w  [2];
  logic [AW-1:0] rem_w   [2];
  logic [DW-1:0] rdata_w [2];
  logic [AW-1:0] mem_addr_d;

  assign req_w[0]  = req0_i;
  assign req_w[1]  = req1_i;
  assign base_w[0] = base0_i;
  assign base_w[1] = base1_i;
  assign len_w[0]  = len0_i;
  assign len_w[1]  = len1_i;

  // ------------------------------------------------------------------
  // Per-requester burst tracker.
  // Each tracker holds:
  //   - capture of the request
  //   - the current address and the remaining-beat count
  //   - completion, and the registered return of read data
  // ------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_req
      logic          busy_q;
      logic          done_q;
      logic          rvalid_q;
      logic [AW-1:0] addr_q;
      logic [AW-1:0] rem_q;
      logic [DW-1:0] rdata_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          rvalid_q <= 1'b0;
          addr_q   <= '0;
          rem_q    <= '0;
          rdata_q  <= '0;
        end else begin
          done_q   <= 1'b0;
          rvalid_q <= issue_w[gi];
          if (issue_w[gi]) begin
            // Beat issued this cycle.
            // The data is captured now, so it appears with rvalid one
            // cycle later. On the final beat, busy drops and done pulses
            // together with that last rvalid.
            rdata_q <= mem_data_i;
            addr_q  <= addr_q + AW'(1);
            rem_q   <= rem_q - AW'(1);
            if (rem_q == AW'(1)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else if (busy_q && (rem_q == '0)) begin
            // Zero-length burst.
            // It is busy for a single cycle and completes with no beats.
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (!busy_q && req_w[gi]) begin
            // A request is only sampled while not busy.
            // This includes the done cycle, so bursts can run back to back.
            busy_q <= 1'b1;
            addr_q <= base_w[gi];
            rem_q  <= len_w[gi];
          end
        end
      end

      assign busy_w[gi]   = busy_q;
      assign done_w[gi]   = done_q;
      assign rvalid_w[gi] = rvalid_q;
      assign addr_w[gi]   = addr_q;
      assign rem_w[gi]    = rem_q;
      assign rdata_w[gi]  = rdata_q;

      // A requester competes for the port only while it has beats left.
      // This keeps a zero-length burst from ever taking a grant.
      assign active_w[gi] = busy_q && (rem_q != '0);
    end
  endgenerate

  // ------------------------------------------------------------------
  // FSM process 1: state register and grant chunk counter.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      chunk_q <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM process 2: next-state logic.
  // In a grant state the decision uses the beat being issued this cycle:
  //   - "last"      : this beat empties the count.
  //   - "chunk full": this is the CHUNK-th beat of the grant.
  // That lets the next owner issue in the very next cycle.
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    case (state_q)
      IDLE: begin
        chunk_d = '0;
        if (active_w[0]) begin
          state_d = GNT0;
        end else if (active_w[1]) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (rem_w[0] <= AW'(1)) begin
          chunk_d = '0;
          state_d = active_w[1] ? GNT1 : IDLE;
        end else if (chunk_q == CW'(CHUNK - 1)) begin
          // The grant continues if the other side is idle.
          // Either way a fresh chunk starts.
          chunk_d = '0;
          if (active_w[1]) begin
            state_d = GNT1;
          end
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end
      GNT1: begin
        if (rem_w[1] <= AW'(1)) begin
          chunk_d = '0;
          state_d = active_w[0] ? GNT0 : IDLE;
        end else if (chunk_q == CW'(CHUNK - 1)) begin
          chunk_d = '0;
          if (active_w[0]) begin
            state_d = GNT0;
          end
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        chunk_d = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // FSM process 3: outputs (beat issue and memory port).
  // ------------------------------------------------------------------
  always_comb begin
    issue_w    = 2'b00;
    mem_addr_d = last_addr_q;
    case (state_q)
      GNT0: begin
        if (rem_w[0] != '0) begin
          issue_w[0] = 1'b1;
          mem_addr_d = addr_w[0];
        end
      end
      GNT1: begin
        if (rem_w[1] != '0) begin
          issue_w[1] = 1'b1;
          mem_addr_d = addr_w[1];
        end
      end
      default: begin
        issue_w    = 2'b00;
        mem_addr_d = last_addr_q;
      end
    endcase
  end

  // Remember the last address driven, so the port holds still when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_addr_q <= '0;
    end else if (|issue_w) begin
      last_addr_q <= mem_addr_d;
    end
  end

  assign mem_rd_o   = |issue_w;
  assign mem_addr_o = mem_addr_d;
  assign busy0_o    = busy_w[0];
  assign busy1_o    = busy_w[1];
  assign done0_o    = done_w[0];
  assign done1_o    = done_w[1];
  assign rvalid0_o  = rvalid_w[0];
  assign rvalid1_o  = rvalid_w[1];
  assign rdata0_o   = rdata_w[0];
  assign rdata1_o   = rdata_w[1];

endmodule

// File: tb/tb_hht_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hht_mem_arbiter
//
// Bench for hht_mem_arbiter:
//   - Stimulus drives bursts and pushes the expected read words into a
//     per-requester scoreboard. The expected words are taken from a
//     behavioural memory model.
//   - A monitor on the falling edge pops the scoreboard and compares
//     whenever rvalid or done is seen.
//   - It also logs every issued memory address.
// ---------------------------------------------------------------------------
module tb_hht_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CHUNK = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] base0 = '0, base1 = '0, len0 = '0, len1 = '0;
  logic          busy0, busy1, done0, done1, rvalid0, rvalid1, mem_rd;
  logic [DW-1:0] rdata0, rdata1, mem_data;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  hht_mem_arbiter #(.CHUNK(CHUNK), .AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .base0_i(base0), .len0_i(len0),
    .req1_i(req1), .base1_i(base1), .len1_i(len1),
    .busy0_o(busy0), .busy1_o(busy1), .done0_o(done0), .done1_o(done1),
    .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data)
  );

  // Behavioural memory: 1024 words, aliased on the low address bits.
  logic [DW-1:0] mem_model [0:1023];
  assign mem_data = mem_model[mem_addr[9:0]];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [DW-1:0] data_q [2][$];   // expected read words per requester
  int            left_q [2][$];   // beats still expected per accepted burst
  int            iss_q  [$];      // cycles in which a beat was issued
  logic [AW-1:0] addr_log [$];
  int            addr_cyc [$];
  int            done_cnt [2] = '{0, 0};
  int            last_done_cyc [2] = '{0, 0};
  int            busy0_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic note_done(input int n);
    done_cnt[n]++;
    last_done_cyc[n] = cyc;
    $display("burst on requester %0d complete at cycle %0d", n, cyc);
  endtask

  task automatic mon_req(input int n, input logic rv, input logic dn, input logic [DW-1:0] rd);
    if (rv) begin
      if (iss_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rvalid_latency%0d: got rvalid with no beat issued, expected none", n);
      end else begin
        chk($sformatf("rvalid_latency%0d", n), cyc, iss_q.pop_front() + 1);
      end
      if (data_q[n].size() == 0 || left_q[n].size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rvalid%0d: got rvalid=1, expected 0", n);
      end else begin
        chk($sformatf("rdata%0d", n), rd, data_q[n].pop_front());
        left_q[n][0] = left_q[n][0] - 1;
        if (left_q[n][0] == 0) begin
          chk($sformatf("done_with_last%0d", n), dn, 1);
          void'(left_q[n].pop_front());
          note_done(n);
        end else begin
          chk($sformatf("no_early_done%0d", n), dn, 0);
        end
      end
    end else if (dn) begin
      if (left_q[n].size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done%0d: got done=1, expected 0", n);
      end else begin
        chk($sformatf("zero_len_done%0d", n), left_q[n][0], 0);
        if (left_q[n][0] == 0) begin
          void'(left_q[n].pop_front());
          note_done(n);
        end
      end
    end
  endtask

  // Monitor: rvalid is handled before this cycle's issue is logged.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_req(0, rvalid0, done0, rdata0);
      mon_req(1, rvalid1, done1, rdata1);
      if (busy0) busy0_cnt++;
      if (mem_rd) begin
        addr_log.push_back(mem_addr);
        addr_cyc.push_back(cyc);
        iss_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: a burst returns mem[(base+i) mod 2^AW] for i in 0..len-1.
  task automatic push_burst(input int n, input logic [AW-1:0] b, input logic [AW-1:0] l);
    logic [AW-1:0] a;
    for (int i = 0; i < int'(l); i++) begin
      a = b + AW'(i);
      data_q[n].push_back(mem_model[a[9:0]]);
    end
    left_q[n].push_back(int'(l));
  endtask

  // One-cycle request pulse.
  // A request counts as accepted only when the requester is not busy.
  task automatic drive(input bit r0, input logic [AW-1:0] b0, input logic [AW-1:0] l0,
                       input bit r1, input logic [AW-1:0] b1, input logic [AW-1:0] l1);
    req0 = r0;
    base0 = b0;
    len0 = l0;
    req1 = r1;
    base1 = b1;
    len1 = l1;
    if (r0 && !busy0) push_burst(0, b0, l0);
    if (r1 && !busy1) push_burst(1, b1, l1);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((left_q[0].size() != 0 || left_q[1].size() != 0 || busy0 || busy1) && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got outstanding bursts after %0d cycles, expected none", k);
    end
  endtask

  task automatic clear_log();
    addr_log.delete();
    addr_cyc.delete();
  endtask

  task automatic chk_addrs(input string name, input logic [AW-1:0] exp [$]);
    chk({name, "_count"}, addr_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < addr_log.size(); i++) begin
      chk($sformatf("%s_addr%0d", name, i), addr_log[i], exp[i]);
      chk($sformatf("%s_cycle%0d", name, i), addr_cyc[i], addr_cyc[0] + i);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy0"}, busy0, 0);
    chk({tag, "_busy1"}, busy1, 0);
    chk({tag, "_done0"}, done0, 0);
    chk({tag, "_done1"}, done1, 0);
    chk({tag, "_rvalid0"}, rvalid0, 0);
    chk({tag, "_rvalid1"}, rvalid1, 0);
    chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [AW-1:0] exp [$];
    int c, k, dc;
    bit r0, r1;
    logic [AW-1:0] b0, b1, l0, l1;

    for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
    mem_model[340] = 29;
    mem_model[341] = 18;
    mem_model[342] = 21;
    mem_model[343] = 27;
    mem_model[2]   = 85;
    mem_model[3]   = 70;
    mem_model[4]   = 83;
    mem_model[350] = 6;
    mem_model[351] = 8;
    mem_model[352] = 15;

    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single burst on requester 0
    clear_log();
    drive(1, 340, 4, 0, 0, 0);
    drain();
    exp = '{340, 341, 342, 343};
    chk_addrs("burst0", exp);

    // Single burst on requester 1
    clear_log();
    drive(0, 0, 0, 1, 2, 3);
    drain();
    exp = '{2, 3, 4};
    chk_addrs("burst1", exp);

    // Simultaneous requests: chunked interleave with no gaps
    clear_log();
    drive(1, 340, 10, 1, 2, 3);
    drain();
    exp = '{340, 341, 342, 343, 344, 345, 346, 347, 2, 3, 4, 348, 349};
    chk_addrs("interleave", exp);
    chk("done1_before_done0", last_done_cyc[1] < last_done_cyc[0], 1);

    // Zero-length burst
    clear_log();
    busy0_cnt = 0;
    c = cyc;
    drive(1, 500, 0, 0, 0, 0);
    drain();
    chk("zero_len_beats", addr_log.size(), 0);
    chk("zero_len_busy_cycles", busy0_cnt, 1);
    chk("zero_len_done_cycle", last_done_cyc[0], c + 2);

    // Request masking while busy
    clear_log();
    drive(1, 340, 4, 0, 0, 0);
    drive(1, 2, 3, 0, 0, 0);
    drive(1, 600, 5, 0, 0, 0);
    drain();
    exp = '{340, 341, 342, 343};
    chk_addrs("masked", exp);

    // Reset in the middle of a burst
    clear_log();
    dc = done_cnt[0];
    drive(1, 100, 6, 0, 0, 0);
    k = 0;
    while (addr_log.size() < 2 && k < 20) begin
      tick();
      k++;
    end
    chk("midreset_two_beats", addr_log.size(), 2);
    rst_n = 1'b0;
    #1;
    data_q[0].delete();
    data_q[1].delete();
    left_q[0].delete();
    left_q[1].delete();
    iss_q.delete();
    chk_reset_outputs("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midreset_no_done", done_cnt[0], dc);
    clear_log();
    drive(1, 350, 2, 0, 0, 0);
    drain();
    exp = '{350, 351};
    chk_addrs("after_reset", exp);

    // Back-to-back burst accepted in the done cycle
    clear_log();
    drive(1, 350, 2, 0, 0, 0);
    k = 0;
    while (done0 !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("b2b_done_seen", done0, 1);
    c = cyc;
    drive(1, 352, 1, 0, 0, 0);
    drain();
    exp = '{350, 351, 352};
    chk("b2b_count", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      chk("b2b_addr", addr_log[2], 352);
      chk("b2b_issue_cycle", addr_cyc[2], c + 2);
    end

    // Address wrap modulo 2^AW
    clear_log();
    drive(1, 32'hFFFF_FFFE, 4, 0, 0, 0);
    drain();
    exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1};
    chk_addrs("wrap", exp);

    // Randomized traffic, including requests while busy and zero lengths
    for (int it = 0; it < 400; it++) begin
      r0 = ($urandom_range(0, 3) == 0);
      r1 = ($urandom_range(0, 3) == 0);
      b0 = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF - AW'($urandom_range(0, 5))) : AW'($urandom_range(0, 1023));
      b1 = AW'($urandom_range(0, 1023));
      l0 = AW'($urandom_range(0, 12));
      l1 = AW'($urandom_range(0, 20));
      drive(r0, b0, l0, r1, b1, l1);
    end
    drain();
    chk("final_queue0_empty", data_q[0].size(), 0);
    chk("final_queue1_empty", data_q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
